// File: rtl/rr_mux_arbiter_8.sv
// Round-robin arbiter for eight requesters sharing a 2-bit 8:1 mux.
// The winner's data is captured into an output register and handed off with valid/ready.
module rr_mux_arbiter_8 (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  req,
    input  logic [15:0] data_in,
    input  logic        out_ready,
    output logic [7:0]  grant,
    output logic [2:0]  select,
    output logic        out_valid,
    output logic [1:0]  out_data,
    output logic        busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  ptr_q, ptr_d;
    logic [7:0]  grant_q, grant_d;
    logic [2:0]  select_q, select_d;
    logic        out_valid_q, out_valid_d;
    logic [1:0]  out_data_q, out_data_d;

    logic [2:0]  base;
    logic [7:0]  req_rot;
    logic [1:0]  lane [8];
    logic [2:0]  offset;
    logic        found;
    logic [2:0]  winner;

    // During a tenure the next search starts just past the current winner,
    // which equals the pointer value that the transfer will commit.
    always_comb begin
        base = (state_q == S_GRANT) ? (select_q + 3'd1) : ptr_q;
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign lane[gi]    = data_in[2*gi +: 2];
            assign req_rot[gi] = req[base + 3'(gi)];
        end
    endgenerate

    // Lowest rotated offset wins; scanning downward leaves the smallest set index.
    always_comb begin
        found  = 1'b0;
        offset = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (req_rot[k]) begin
                found  = 1'b1;
                offset = 3'(k);
            end
        end
        winner = base + offset;
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        select_d    = select_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d     = S_GRANT;
                    grant_d     = 8'b1 << winner;
                    select_d    = winner;
                    out_data_d  = lane[winner];
                    out_valid_d = 1'b1;
                end
            end
            S_GRANT: begin
                if (out_ready) begin
                    ptr_d = select_q + 3'd1;
                    if (found) begin
                        grant_d    = 8'b1 << winner;
                        select_d   = winner;
                        out_data_d = lane[winner];
                    end else begin
                        state_d     = S_IDLE;
                        grant_d     = 8'd0;
                        out_valid_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= 3'd0;
            grant_q     <= 8'd0;
            select_q    <= 3'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            select_q    <= select_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign grant     = grant_q;
    assign select    = select_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = out_valid_q;

endmodule

// File: tb/tb_rr_mux_arbiter_8.sv
// Directed and randomized checks of rr_mux_arbiter_8 against a behavioural model
// of the round-robin and handshake rules.
module tb_rr_mux_arbiter_8;

    logic        clock;
    logic        reset;
    logic [7:0]  req;
    logic [15:0] data_in;
    logic        out_ready;
    logic [7:0]  grant;
    logic [2:0]  select;
    logic        out_valid;
    logic [1:0]  out_data;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic        m_valid;
    logic [7:0]  m_grant;
    logic [2:0]  m_sel;
    logic [1:0]  m_data;
    logic [2:0]  m_ptr;

    rr_mux_arbiter_8 dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .data_in   (data_in),
        .out_ready (out_ready),
        .grant     (grant),
        .select    (select),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // First requester at or after 'from', wrapping modulo 8; -1 if none.
    function automatic int find_winner(input int from, input logic [7:0] r);
        for (int k = 0; k < 8; k++) begin
            if (r[(from + k) % 8]) return (from + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_take(input int w, input logic [15:0] d);
        m_valid = 1'b1;
        m_grant = 8'd0;
        m_grant[w] = 1'b1;
        m_sel   = 3'(w);
        m_data  = d[2*w +: 2];
    endtask

    task automatic model_update(input logic [7:0] r, input logic [15:0] d,
                                input logic rdy, input logic rst);
        int w;
        if (rst) begin
            m_valid = 1'b0; m_grant = 8'd0; m_sel = 3'd0; m_data = 2'd0; m_ptr = 3'd0;
        end else if (!m_valid) begin
            w = find_winner(int'(m_ptr), r);
            if (w >= 0) model_take(w, d);
        end else if (rdy) begin
            m_ptr = 3'((int'(m_sel) + 1) % 8);
            w = find_winner(int'(m_ptr), r);
            if (w >= 0) model_take(w, d);
            else begin
                m_valid = 1'b0;
                m_grant = 8'd0;
            end
        end
    endtask

    task automatic step(input logic [7:0] r, input logic [15:0] d,
                        input logic rdy, input logic rst);
        req = r; data_in = d; out_ready = rdy; reset = rst;
        @(posedge clock);
        model_update(r, d, rdy, rst);
        #1;
        check("grant",     32'(grant),     32'(m_grant));
        check("select",    32'(select),    32'(m_sel));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data",  32'(out_data),  32'(m_data));
        check("busy",      32'(busy),      32'(m_valid));
    endtask

    initial begin
        logic [15:0] d;
        logic [7:0]  r;
        m_valid = 1'b0; m_grant = 8'd0; m_sel = 3'd0; m_data = 2'd0; m_ptr = 3'd0;
        req = 8'd0; data_in = 16'd0; out_ready = 1'b0; reset = 1'b1;

        // Reset with everything requesting
        step(8'hFF, 16'hFFFF, 1'b1, 1'b1);
        check("rst_grant_zero", 32'(grant), 32'h0);
        check("rst_valid_zero", 32'(out_valid), 32'h0);
        step(8'hFF, 16'hFFFF, 1'b1, 1'b0);
        check("first_after_rst_sel0", 32'(select), 32'h0);

        // Single request from requester 5
        step(8'h00, 16'h0000, 1'b0, 1'b1);
        step(8'h20, 16'h0C00, 1'b0, 1'b0);
        check("single_grant", 32'(grant), 32'h20);
        check("single_select", 32'(select), 32'h5);
        check("single_data", 32'(out_data), 32'h3);
        step(8'h00, 16'h0000, 1'b1, 1'b0);
        check("single_done_valid", 32'(out_valid), 32'h0);

        // Wrap between requesters 0 and 7
        step(8'h00, 16'h0000, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(8'h81, 16'($urandom), 1'b1, 1'b0);
            check("wrap_select", 32'(select), (i % 2 == 0) ? 32'h0 : 32'h7);
            check("wrap_valid", 32'(out_valid), 32'h1);
        end

        // Backpressure on requester 3
        step(8'h00, 16'h0000, 1'b0, 1'b1);
        step(8'h08, 16'h0080, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            d = (i % 2 == 0) ? 16'h0040 : 16'h00C0;
            step(8'h00, d, 1'b0, 1'b0);
            check("bp_grant", 32'(grant), 32'h08);
            check("bp_data", 32'(out_data), 32'h2);
        end
        step(8'h00, 16'h0000, 1'b1, 1'b0);
        check("bp_xfer_valid", 32'(out_valid), 32'h0);

        // Fairness with all requesting
        step(8'h00, 16'h0000, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            step(8'hFF, 16'($urandom), 1'b1, 1'b0);
            check("fair_select", 32'(select), 32'(i % 8));
            check("fair_onehot", 32'($countones(grant)), 32'h1);
        end

        // Reset in the middle of a tenure
        step(8'h00, 16'h0000, 1'b0, 1'b1);
        step(8'h40, 16'h2000, 1'b0, 1'b0);
        check("mid_sel6", 32'(select), 32'h6);
        step(8'h40, 16'h0000, 1'b0, 1'b0);
        step(8'h41, 16'h0000, 1'b0, 1'b1);
        check("mid_rst_grant", 32'(grant), 32'h0);
        step(8'h41, 16'h0001, 1'b0, 1'b0);
        check("mid_after_sel0", 32'(select), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = 8'($urandom);
            if ($urandom_range(0, 2) == 0) r = r & 8'($urandom);
            step(r, 16'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 59) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
